// File: rtl/multicycle_ctrl_v2.sv
// Multi-cycle control FSM for the 16-bit CR16-style core: fetch/decode/exec/mem/wb,
// conditional branches, JAL link, req/ack data memory with timeout, and a sticky trap state.
module multicycle_ctrl_v2 #(
  parameter int unsigned IW          = 16,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [IW-1:0] instruction,
  input  logic [4:0]    psrFlags,
  input  logic          memAck,
  output logic          pcEn,
  output logic          pcIncOrSet,
  output logic          irEn,
  output logic          rfWe,
  output logic          pcRegSel,
  output logic          r2ImSel,
  output logic [1:0]    immTypeSel,
  output logic          psrEn,
  output logic          memReq,
  output logic          memWe,
  output logic [1:0]    wbSel,
  output logic          trap,
  output logic [1:0]    trapCause,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b111
  } state_t;

  localparam bit             TO_ON   = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          cur;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      cause_q;

  logic [3:0] opcode, ext, cond;
  logic       is_alu, is_cmp, use_imm, is_load, is_store, is_jcond, is_jal, is_bcond;
  logic       legal, cond_true, timeout_hit;
  logic [1:0] imm_sel;
  logic       unused_ok;

  assign opcode      = instruction[IW-1 -: 4];
  assign ext         = instruction[7:4];
  assign cond        = instruction[11:8];
  assign legal       = is_alu | is_load | is_store | is_jcond | is_jal | is_bcond;
  assign timeout_hit = TO_ON && (to_cnt == TO_LAST);
  assign unused_ok   = ^{instruction, psrFlags};

  // Instruction class decode; the IR is stable from EXEC through WB.
  always_comb begin
    is_alu   = 1'b0;
    is_cmp   = 1'b0;
    use_imm  = 1'b0;
    imm_sel  = 2'b00;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_jcond = 1'b0;
    is_jal   = 1'b0;
    is_bcond = 1'b0;
    case (opcode)
      4'b0000: begin
        is_alu = 1'b1;
        is_cmp = (ext == 4'b1011);
      end
      4'b0001, 4'b0010, 4'b0011, 4'b1101: begin
        is_alu  = 1'b1;
        use_imm = 1'b1;
        imm_sel = 2'b10;
      end
      4'b0101, 4'b1001: begin
        is_alu  = 1'b1;
        use_imm = 1'b1;
        imm_sel = 2'b01;
      end
      4'b1011: begin
        is_alu  = 1'b1;
        is_cmp  = 1'b1;
        use_imm = 1'b1;
        imm_sel = 2'b01;
      end
      4'b1000, 4'b1111: begin
        is_alu  = 1'b1;
        use_imm = 1'b1;
      end
      4'b0100: begin
        case (ext)
          4'b0000: is_load  = 1'b1;
          4'b0100: is_store = 1'b1;
          4'b1100: is_jcond = 1'b1;
          4'b1000: is_jal   = 1'b1;
          default: ;
        endcase
      end
      4'b1100: is_bcond = 1'b1;
      default: ;
    endcase
  end

  // Branch condition against {N,Z,F,L,C}.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'b0000: cond_true = psrFlags[3];
      4'b0001: cond_true = ~psrFlags[3];
      4'b0010: cond_true = psrFlags[0];
      4'b0011: cond_true = ~psrFlags[0];
      4'b0100: cond_true = psrFlags[1];
      4'b0101: cond_true = ~psrFlags[1];
      4'b0110: cond_true = psrFlags[4];
      4'b0111: cond_true = ~psrFlags[4];
      4'b1100: cond_true = psrFlags[4] | psrFlags[3];
      4'b1101: cond_true = ~psrFlags[4] & ~psrFlags[3];
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // State, memory wait counter and trap cause.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur     <= S_FETCH;
      to_cnt  <= '0;
      cause_q <= 2'b00;
    end else begin
      case (cur)
        S_FETCH:  cur <= S_DECODE;
        S_DECODE: cur <= S_EXEC;
        S_EXEC: begin
          to_cnt <= '0;
          if (!legal) begin
            cur     <= S_TRAP;
            cause_q <= 2'b01;
          end else if (is_cmp) begin
            cur <= S_FETCH;
          end else if (is_load || is_store) begin
            cur <= S_MEM;
          end else begin
            cur <= S_WB;
          end
        end
        S_MEM: begin
          if (memAck) begin
            cur    <= S_WB;
            to_cnt <= '0;
          end else if (timeout_hit) begin
            cur     <= S_TRAP;
            cause_q <= 2'b10;
            to_cnt  <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_WB:    cur <= S_FETCH;
        S_TRAP:  cur <= S_TRAP;
        default: cur <= S_FETCH;
      endcase
    end
  end

  // Control outputs decoded from state and the held instruction.
  always_comb begin
    pcEn       = 1'b0;
    pcIncOrSet = 1'b0;
    irEn       = 1'b0;
    rfWe       = 1'b0;
    pcRegSel   = 1'b1;
    r2ImSel    = 1'b0;
    immTypeSel = 2'b00;
    psrEn      = 1'b0;
    memReq     = 1'b0;
    memWe      = 1'b0;
    wbSel      = 2'b00;
    trap       = 1'b0;
    case (cur)
      S_DECODE: irEn = 1'b1;
      S_EXEC: begin
        if (is_alu) begin
          psrEn      = 1'b1;
          r2ImSel    = use_imm;
          immTypeSel = imm_sel;
          pcEn       = is_cmp;
        end else if (is_jcond || is_jal || is_bcond) begin
          pcRegSel   = 1'b0;
          r2ImSel    = 1'b1;
          immTypeSel = is_bcond ? 2'b01 : 2'b11;
        end
      end
      S_MEM: begin
        memReq = 1'b1;
        memWe  = is_store;
      end
      S_WB: begin
        pcEn = 1'b1;
        if (is_jcond || is_bcond) begin
          pcIncOrSet = cond_true;
        end else if (is_jal) begin
          rfWe       = 1'b1;
          wbSel      = 2'b10;
          pcIncOrSet = 1'b1;
        end else if (is_load) begin
          rfWe  = 1'b1;
          wbSel = 2'b01;
        end else if (!is_store) begin
          rfWe = 1'b1;
        end
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign state     = cur;
  assign trapCause = cause_q;

endmodule

// File: doc/multicycle_ctrl_v2.md
Name: multicycle_ctrl_v2

Overview:
- Parametrised successor to the processor's multi-cycle control FSM.
- Sequences fetch, decode, execute, memory and write-back for the 16-bit CR16-style ISA, and drives PC, IR, register-file, ALU-mux, PSR and data-memory control.
- Adds three things to the previous generation: conditional branches/jumps evaluated against PSR flags, JAL link write-back, and a req/ack data-memory handshake with wait states.
- Adds a trap state for illegal opcodes and memory timeouts.

Parameters:
- IW, 16: instruction width, must be ≥16. Opcode is instruction[IW-1:IW-4], ext is [7:4], cond is [11:8].
- MEM_TIMEOUT, 15: maximum cycles waiting for memAck before trapping. 0 disables the timeout.
- TO_W, 4: timeout counter width, must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instruction  in  IW  instruction from IR
- psrFlags  in  5  {N,Z,F,L,C}; bit0=C, bit3=Z, bit4=N
- memAck  in  1  data memory done, sampled in MEM state
- pcEn  out  1  PC update enable
- pcIncOrSet  out  1  0 = PC+1, 1 = PC loads ALU/target
- irEn  out  1  IR load
- rfWe  out  1  register-file write
- pcRegSel  out  1  ALU A source: 1 = Rsrc, 0 = PC
- r2ImSel  out  1  ALU B source: 1 = immediate
- immTypeSel  out  2  00 raw, 01 sign-ext, 10 zero-ext, 11 jump-target
- psrEn  out  1  PSR update
- memReq  out  1  data memory request (held through MEM)
- memWe  out  1  data memory write (STORE)
- wbSel  out  2  00 ALU, 01 memory data, 10 PC+1 (link)
- trap  out  1  high while in TRAP
- trapCause  out  2  01 illegal opcode, 10 memory timeout, 00 none
- state  out  3  current state, for debug

Behaviour:
- States: FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, TRAP=111. All outputs are combinational from state and instruction.
- Defaults in every state: all outputs 0, except pcRegSel=1 and wbSel=00.
- Reset (asynchronous, takes effect on assertion): state=FETCH, timeout counter=0, trapCause=00. Outputs then take their FETCH values, i.e. the defaults.
- FETCH → DECODE, unconditionally.
- DECODE: irEn=1 → EXEC.
- EXEC, ALU types (psrEn=1 for all of these):
  - R-type (0000): r2ImSel=0.
  - ANDI/ORI/XORI/MOVI (0001/0010/0011/1101): r2ImSel=1, imm=10.
  - ADDI/SUBI (0101/1001): imm=01.
  - LSHI/LUI (1000/1111): imm=00.
  - CMP (0000 with ext 1011) and CMPI (1011, imm=01): pcEn=1, pcIncOrSet=0 → FETCH. Compares skip WB.
  - All other ALU types → WB.
- EXEC, opcode 0100 (psrEn=0):
  - LOAD ext 0000 → MEM.
  - STORE ext 0100 → MEM.
  - Jcond ext 1100: pcRegSel=0, r2ImSel=1, imm=11 → WB.
  - JAL ext 1000: same controls as Jcond → WB.
  - Any other ext → TRAP, cause 01.
- EXEC, Bcond (1100): pcRegSel=0, r2ImSel=1, imm=01, psrEn=0 → WB.
- EXEC, any other opcode (0110, 0111, 1010, 1110) → TRAP, cause 01.
- Condition evaluation, on cond field:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: L
  - 0101 LS: !L
  - 0110 GT: N
  - 0111 LE: !N
  - 1100 GE: N|Z
  - 1101 LT: !N&!Z
  - 1110 UC: 1
  - all others: 0
  - Flags are sampled in WB. psrEn=0 for branches, so flags are stable.
- MEM:
  - memReq=1, and memWe=1 for STORE.
  - The counter increments each cycle memAck=0.
  - memAck=1 → WB, counter cleared. memAck takes priority over timeout in the same cycle.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with memAck=0 → TRAP, cause 10.
  - Minimum memory latency (memAck already high on first MEM cycle) = 1 MEM cycle.
- WB: pcEn=1, then → FETCH.
  - ALU op: rfWe=1, wbSel=00.
  - LOAD: rfWe=1, wbSel=01.
  - STORE: rfWe=0.
  - Jcond/Bcond: rfWe=0, pcIncOrSet=condition result.
  - JAL: rfWe=1, wbSel=10, pcIncOrSet=1.
- TRAP: all control outputs at default, pcEn=0, trap=1, trapCause held. Remains in TRAP until reset.
- Cycle counts:
  - ALU op: 4
  - CMP/CMPI: 3
  - LOAD/STORE: 5+wait
  - branches/jumps: 4
- Reset mid-operation: any state returns to FETCH immediately. No partial write is issued after reset.

Test Plan:
- ADDI r1,#-3 (0x51FD) → DECODE irEn=1; EXEC r2ImSel=1, imm=01, psrEn=1; WB rfWe=1, pcEn=1, pcIncOrSet=0; 4 cycles.
- CMP (0x0xBx) → EXEC pcEn=1, psrEn=1; FETCH next cycle; rfWe never asserted.
- Bcond EQ (0xC0xx):
  - Z=1 → WB pcIncOrSet=1.
  - Z=0 → pcIncOrSet=0.
  - UC (cond 1110) → always 1.
  - cond 1111 → always 0.
- LOAD with memAck after 3 cycles → memReq high 3 cycles, memWe=0, then WB wbSel=01, rfWe=1.
- STORE with memAck low (MEM_TIMEOUT=15) → memReq, memWe high 15 cycles; then trap=1, trapCause=10; stays until reset. memAck rising on cycle 15 → WB, no trap.
- Opcode 0111, and 0100 with ext 1111 → trap=1, trapCause=01. Reset asserted mid-MEM → state=000, memReq=0 asynchronously.
